prescale_timer: RTL

- Programmable prescaled down-timer that generates the single-cycle enable/tick pulses driving downstream counters such as the 4-bit free-running counter.
- Sits directly upstream of the counter stages.
- Converts `clk` into a slower, software-configured tick rate.
- Supports one-shot and periodic modes, with `busy`/`done` status.

---
 rtl/timer_pkg.sv | 16 +
 rtl/prescale_div.sv | 43 ++++
 rtl/prescale_timer.sv | 112 +++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and default widths for the prescaled down-timer.
//   timer_state_t : timer FSM states (idle, running, one-shot expired)
//   PW_DEF        : default prescale divider width
//   CW_DEF        : default reload / main countdown width
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  localparam int unsigned PW_DEF = 8;
  localparam int unsigned CW_DEF = 16;

endpackage

// File: rtl/prescale_div.sv
// Prescale divider: counts enabled cycles and emits a one-cycle step every div+1 of them.
//   clk   : system clock (posedge)
//   reset : synchronous active-high reset, clears the divider count
//   clr   : synchronous clear of the divider count (restart)
//   en    : advance the divider this cycle
//   div   : divider value P; step fires when the count reaches P
//   step  : combinational step strobe, only ever high while en is high
module prescale_div
  import timer_pkg::*;
#(
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [PW-1:0] div,
  output logic          step
);

  logic [PW-1:0] pcnt_q, pcnt_d;

  // pcnt never passes div, so all-ones div cannot overflow the field.
  assign step = en && (pcnt_q == div);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = step ? '0 : pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/prescale_timer.sv
// Programmable prescaled down-timer producing single-cycle enable ticks for downstream counters.
// A tick fires every (prescale+1)*(reload+1) cycles; one-shot or periodic.
//   clk      : system clock (posedge)
//   reset    : synchronous active-high reset, highest priority
//   start    : strobe; latches config and (re)starts the timer
//   stop     : strobe; aborts to IDLE, wins over start
//   periodic : sampled on start; 1 = auto-reload, 0 = one-shot
//   prescale : sampled on start; divider value P
//   reload   : sampled on start; countdown value R
//   tick     : registered one-cycle enable pulse
//   busy     : high while running
//   done     : high while a one-shot run has expired (level)
//   count    : current main countdown value
module prescale_timer
  import timer_pkg::*;
#(
  parameter int unsigned PW = PW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic [PW-1:0] prescale,
  input  logic [CW-1:0] reload,
  output logic          tick,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);

  timer_state_t  state_q, state_d;
  logic [PW-1:0] p_sh_q, p_sh_d;
  logic [CW-1:0] r_sh_q, r_sh_d;
  logic          per_sh_q, per_sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  logic div_clr;
  logic div_en;
  logic step;

  // Divider only runs on plain RUN cycles; any command this cycle overrides stepping.
  // stop leaves pcnt untouched, start (without stop) discards partial progress.
  assign div_clr = start && !stop;
  assign div_en  = (state_q == RUN) && !start && !stop;

  prescale_div #(
    .PW(PW)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .clr  (div_clr),
    .en   (div_en),
    .div  (p_sh_q),
    .step (step)
  );

  always_comb begin
    state_d  = state_q;
    p_sh_d   = p_sh_q;
    r_sh_d   = r_sh_q;
    per_sh_d = per_sh_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      p_sh_d   = prescale;
      r_sh_d   = reload;
      per_sh_d = periodic;
      cnt_d    = reload;
      state_d  = RUN;
    end else if (step) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        tick_d = 1'b1;
        if (per_sh_q) begin
          cnt_d = r_sh_q;
        end else begin
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      p_sh_q   <= '0;
      r_sh_q   <= '0;
      per_sh_q <= 1'b0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_sh_q   <= p_sh_d;
      r_sh_q   <= r_sh_d;
      per_sh_q <= per_sh_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

  assign tick  = tick_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign count = cnt_q;

endmodule
